// File: rtl/power_switch_sequencer.sv
// Per-domain power-switch sequencer: isolation, retention save/restore, switch/ack handshake, domain reset.
// Optional rush-current staggering of power-up (one domain in ON_REQ at a time) under `POWER_SEQ_STAGGER_EN.
module power_switch_sequencer #(
    parameter int NUM_DOMAINS = 8,
    parameter int STEP_CYCLES = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_DOMAINS-1:0] domain_en_i,
    input  logic [NUM_DOMAINS-1:0] retention_req_i,
    input  logic [NUM_DOMAINS-1:0] pwr_ack_i,
    input  logic                   err_clr_i,
    output logic [NUM_DOMAINS-1:0] pwr_sw_en_o,
    output logic [NUM_DOMAINS-1:0] iso_en_o,
    output logic [NUM_DOMAINS-1:0] save_o,
    output logic [NUM_DOMAINS-1:0] restore_o,
    output logic [NUM_DOMAINS-1:0] domain_rst_no,
    output logic [NUM_DOMAINS-1:0] domain_ready_o,
    output logic [NUM_DOMAINS-1:0] timeout_err_o,
    output logic                   busy_o
);
    localparam int MAX_WAIT = (STEP_CYCLES > ACK_TIMEOUT) ? STEP_CYCLES : ACK_TIMEOUT;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [3:0] {
        ST_ON      = 4'd0,
        ST_ISO     = 4'd1,
        ST_SAVE    = 4'd2,
        ST_OFF_REQ = 4'd3,
        ST_OFF     = 4'd4,
        ST_ON_REQ  = 4'd5,
        ST_RESTORE = 4'd6,
        ST_RST_REL = 4'd7,
        ST_ISO_REL = 4'd8
    } state_e;

    logic [NUM_DOMAINS-1:0] set_err_s;
    logic [NUM_DOMAINS-1:0] busy_s;
    logic [NUM_DOMAINS-1:0] timeout_err_r;
`ifdef POWER_SEQ_STAGGER_EN
    logic [NUM_DOMAINS-1:0] on_req_s;
    logic [NUM_DOMAINS-1:0] contend_s;
`endif

    for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_dom
        state_e           state_r, state_s;
        logic [CNT_W-1:0] cnt_r;
        logic             ret_r, ret_s;
        logic             grant_s, step_done_s, ack_done_s, err_s;
        logic             sw_s, iso_s, save_s, restore_s, rst_n_s, ready_s;

        assign step_done_s = (cnt_r == STEP_LAST);
        assign ack_done_s  = (cnt_r == ACK_LAST);

`ifdef POWER_SEQ_STAGGER_EN
        localparam logic [NUM_DOMAINS-1:0] LOWER_MASK = NUM_DOMAINS'((64'd1 << i) - 64'd1);
        assign on_req_s[i]  = (state_r == ST_ON_REQ);
        assign contend_s[i] = (state_r == ST_OFF) && domain_en_i[i];
        assign grant_s      = ~|on_req_s && ~|(contend_s & LOWER_MASK);
`else
        assign grant_s = 1'b1;
`endif

        // Next-state logic; the ack wait falls through on timeout and flags an error
        always_comb begin
            state_s = state_r;
            ret_s   = ret_r;
            err_s   = 1'b0;
            case (state_r)
                ST_ON: begin
                    if (!domain_en_i[i]) begin
                        state_s = ST_ISO;
                        ret_s   = retention_req_i[i];
                    end else begin
                        state_s = ST_ON;
                    end
                end
                ST_ISO: begin
                    if (domain_en_i[i]) begin
                        state_s = ST_ISO_REL;
                    end else if (step_done_s) begin
                        state_s = ret_r ? ST_SAVE : ST_OFF_REQ;
                    end else begin
                        state_s = ST_ISO;
                    end
                end
                ST_SAVE: begin
                    if (step_done_s) state_s = ST_OFF_REQ;
                    else             state_s = ST_SAVE;
                end
                ST_OFF_REQ: begin
                    if (!pwr_ack_i[i]) begin
                        state_s = ST_OFF;
                    end else if (ack_done_s) begin
                        state_s = ST_OFF;
                        err_s   = 1'b1;
                    end else begin
                        state_s = ST_OFF_REQ;
                    end
                end
                ST_OFF: begin
                    if (domain_en_i[i] && grant_s) state_s = ST_ON_REQ;
                    else                           state_s = ST_OFF;
                end
                ST_ON_REQ: begin
                    if (pwr_ack_i[i]) begin
                        state_s = ret_r ? ST_RESTORE : ST_RST_REL;
                    end else if (ack_done_s) begin
                        state_s = ret_r ? ST_RESTORE : ST_RST_REL;
                        err_s   = 1'b1;
                    end else begin
                        state_s = ST_ON_REQ;
                    end
                end
                ST_RESTORE: begin
                    if (step_done_s) state_s = ST_RST_REL;
                    else             state_s = ST_RESTORE;
                end
                ST_RST_REL: begin
                    if (step_done_s) state_s = ST_ISO_REL;
                    else             state_s = ST_RST_REL;
                end
                ST_ISO_REL: begin
                    if (step_done_s) state_s = ST_ON;
                    else             state_s = ST_ISO_REL;
                end
                default: state_s = ST_ON;
            endcase
        end

        // State, retention flag and dwell counter (restarts on every state change)
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_r <= ST_ON;
                ret_r   <= 1'b0;
                cnt_r   <= '0;
            end else begin
                state_r <= state_s;
                ret_r   <= ret_s;
                if (state_s != state_r)           cnt_r <= '0;
                else if (cnt_r != {CNT_W{1'b1}})  cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                else                              cnt_r <= cnt_r;
            end
        end

        // Output decode of the registered state
        always_comb begin
            sw_s      = 1'b1;
            rst_n_s   = 1'b1;
            iso_s     = 1'b0;
            save_s    = 1'b0;
            restore_s = 1'b0;
            ready_s   = 1'b0;
            case (state_r)
                ST_ON:      ready_s = 1'b1;
                ST_ISO:     iso_s = 1'b1;
                ST_SAVE:    begin iso_s = 1'b1; save_s = 1'b1; end
                ST_OFF_REQ: begin iso_s = 1'b1; sw_s = 1'b0; rst_n_s = 1'b0; end
                ST_OFF:     begin iso_s = 1'b1; sw_s = 1'b0; rst_n_s = 1'b0; end
                ST_ON_REQ:  begin iso_s = 1'b1; rst_n_s = 1'b0; end
                ST_RESTORE: begin iso_s = 1'b1; rst_n_s = 1'b0; restore_s = 1'b1; end
                ST_RST_REL: iso_s = 1'b1;
                ST_ISO_REL: ready_s = 1'b0;
                default:    ready_s = 1'b0;
            endcase
        end

        assign pwr_sw_en_o[i]    = sw_s;
        assign iso_en_o[i]       = iso_s;
        assign save_o[i]         = save_s;
        assign restore_o[i]      = restore_s;
        assign domain_rst_no[i]  = rst_n_s;
        assign domain_ready_o[i] = ready_s;
        assign set_err_s[i]      = err_s;
        assign busy_s[i]         = (state_r != ST_ON) && (state_r != ST_OFF);
    end

    // Sticky timeout flags; a new set outranks a simultaneous clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) timeout_err_r <= '0;
        else         timeout_err_r <= (timeout_err_r & ~{NUM_DOMAINS{err_clr_i}}) | set_err_s;
    end

    assign timeout_err_o = timeout_err_r;
    assign busy_o        = |busy_s;
endmodule

// File: tb/tb_power_switch_sequencer.sv
// Directed bench for power_switch_sequencer with a phase/timer reference model checked every cycle.
module tb_power_switch_sequencer;
    localparam int N = 4;
    localparam int S = 4;
    localparam int T = 16;
    localparam int M_ON = 0, M_DOWN = 1, M_OFF = 2, M_UP = 3, M_CANCEL = 4;

    logic         clk = 1'b0;
    logic         rst_ni;
    logic [N-1:0] domain_en, ret_req, pwr_ack;
    logic         err_clr;
    logic [N-1:0] sw, iso, save, restore, rst_n, ready, terr;
    logic         busy;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    // reference model: per-domain mode, timers and flags
    int           m_mode [N];
    int           m_t    [N];
    int           m_w    [N];
    bit           m_ret  [N];
    bit           m_wait [N];
    logic [N-1:0] m_err;

    power_switch_sequencer #(.NUM_DOMAINS(N), .STEP_CYCLES(S), .ACK_TIMEOUT(T)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .domain_en_i(domain_en), .retention_req_i(ret_req),
        .pwr_ack_i(pwr_ack), .err_clr_i(err_clr), .pwr_sw_en_o(sw), .iso_en_o(iso),
        .save_o(save), .restore_o(restore), .domain_rst_no(rst_n), .domain_ready_o(ready),
        .timeout_err_o(terr), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < N; d++) begin
            m_mode[d] = M_ON; m_t[d] = 0; m_w[d] = 0; m_ret[d] = 1'b0; m_wait[d] = 1'b0;
        end
        m_err = '0;
    endtask

    task automatic model_step();
        logic         any_onreq;
        logic [N-1:0] contend, set;
        bit           g;
        any_onreq = 1'b0;
        set = '0;
        for (int d = 0; d < N; d++) begin
            if (m_mode[d] == M_UP && m_wait[d]) any_onreq = 1'b1;
            contend[d] = (m_mode[d] == M_OFF) && domain_en[d];
        end
        for (int d = 0; d < N; d++) begin
            case (m_mode[d])
                M_ON: if (!domain_en[d]) begin
                    m_mode[d] = M_DOWN; m_t[d] = 0; m_wait[d] = 1'b0; m_ret[d] = ret_req[d];
                end
                M_DOWN: begin
                    if (!m_wait[d]) begin
                        if (m_t[d] < S && domain_en[d]) begin m_mode[d] = M_CANCEL; m_t[d] = 0; end
                        else if (m_t[d] == (m_ret[d] ? 2 : 1) * S - 1) begin m_wait[d] = 1'b1; m_w[d] = 0; end
                        else m_t[d]++;
                    end else begin
                        if (!pwr_ack[d]) m_mode[d] = M_OFF;
                        else if (m_w[d] == T - 1) begin m_mode[d] = M_OFF; set[d] = 1'b1; end
                        else m_w[d]++;
                    end
                end
                M_OFF: begin
                    g = 1'b1;
`ifdef POWER_SEQ_STAGGER_EN
                    if (any_onreq) g = 1'b0;
                    for (int k = 0; k < d; k++) if (contend[k]) g = 1'b0;
`endif
                    if (domain_en[d] && g) begin m_mode[d] = M_UP; m_wait[d] = 1'b1; m_w[d] = 0; end
                end
                M_UP: begin
                    if (m_wait[d]) begin
                        if (pwr_ack[d]) begin m_wait[d] = 1'b0; m_t[d] = 0; end
                        else if (m_w[d] == T - 1) begin m_wait[d] = 1'b0; m_t[d] = 0; set[d] = 1'b1; end
                        else m_w[d]++;
                    end else begin
                        if (m_t[d] == (m_ret[d] ? 3 : 2) * S - 1) m_mode[d] = M_ON;
                        else m_t[d]++;
                    end
                end
                default: begin
                    if (m_t[d] == S - 1) m_mode[d] = M_ON;
                    else m_t[d]++;
                end
            endcase
        end
        m_err = (m_err & ~{N{err_clr}}) | set;
    endtask

    task automatic model_out(output logic [N-1:0] e_sw, e_iso, e_sv, e_rs, e_rn, e_rdy, output logic e_busy);
        int u;
        e_busy = 1'b0;
        for (int d = 0; d < N; d++) begin
            e_sw[d] = 1'b1; e_rn[d] = 1'b1; e_iso[d] = 1'b0; e_sv[d] = 1'b0; e_rs[d] = 1'b0; e_rdy[d] = 1'b0;
            if (m_mode[d] != M_ON && m_mode[d] != M_OFF) e_busy = 1'b1;
            u = (m_ret[d] ? 3 : 2) * S;
            case (m_mode[d])
                M_ON: e_rdy[d] = 1'b1;
                M_DOWN: begin
                    e_iso[d] = 1'b1;
                    if (m_wait[d]) begin e_sw[d] = 1'b0; e_rn[d] = 1'b0; end
                    else e_sv[d] = (m_t[d] >= S);
                end
                M_OFF: begin e_iso[d] = 1'b1; e_sw[d] = 1'b0; e_rn[d] = 1'b0; end
                M_UP: begin
                    if (m_wait[d]) begin e_iso[d] = 1'b1; e_rn[d] = 1'b0; end
                    else begin
                        e_iso[d] = (m_t[d] < u - S);
                        e_rs[d]  = m_ret[d] && (m_t[d] < S);
                        e_rn[d]  = !(m_ret[d] && (m_t[d] < S));
                    end
                end
                default: e_rdy[d] = 1'b0;
            endcase
        end
    endtask

    // model advances on the sampling edge; outputs compared on the opposite edge
    initial begin
        logic [N-1:0] e_sw, e_iso, e_sv, e_rs, e_rn, e_rdy;
        logic         e_busy;
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_ni) model_reset();
            else         model_step();
            @(negedge clk);
            if (check_en) begin
                model_out(e_sw, e_iso, e_sv, e_rs, e_rn, e_rdy, e_busy);
                chk("m_sw", 32'(sw), 32'(e_sw));
                chk("m_iso", 32'(iso), 32'(e_iso));
                chk("m_save", 32'(save), 32'(e_sv));
                chk("m_restore", 32'(restore), 32'(e_rs));
                chk("m_rst_n", 32'(rst_n), 32'(e_rn));
                chk("m_ready", 32'(ready), 32'(e_rdy));
                chk("m_err", 32'(terr), 32'(m_err));
                chk("m_busy", 32'(busy), 32'(e_busy));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_ni = 1'b0; domain_en = 4'hF; ret_req = 4'h0; pwr_ack = 4'hF; err_clr = 1'b0;
        cyc(3);
        rst_ni = 1'b1;
        check_en = 1'b1;
        cyc(1);
        chk("rst_sw", 32'(sw), 32'h0000_000F);
        chk("rst_rst_n", 32'(rst_n), 32'h0000_000F);
        chk("rst_ready", 32'(ready), 32'h0000_000F);
        chk("rst_iso", 32'(iso), 32'h0000_0000);
        chk("rst_busy", 32'(busy), 32'h0000_0000);
        cyc(4);
        chk("idle_sw", 32'(sw), 32'h0000_000F);

        // domain 0 down, no retention
        domain_en = 4'hE;
        cyc(1);
        chk("d0_iso", 32'(iso), 32'h0000_0001);
        chk("d0_ready", 32'(ready), 32'h0000_000E);
        chk("d0_model_iso", 32'(m_mode[0]), 32'(M_DOWN));
        cyc(3);
        chk("d0_sw_held", 32'(sw), 32'h0000_000F);
        cyc(1);
        chk("d0_sw_off", 32'(sw), 32'h0000_000E);
        chk("d0_rst_n", 32'(rst_n), 32'h0000_000E);
        cyc(2);
        pwr_ack = 4'hE;
        cyc(1);
        chk("d0_off_busy", 32'(busy), 32'h0000_0000);

        // domain 1 down with retention, then back up
        domain_en = 4'hC; ret_req = 4'h2;
        cyc(1);
        ret_req = 4'h0;
        chk("d1_iso", 32'(iso), 32'h0000_0003);
        cyc(3);
        chk("d1_save_pre", 32'(save), 32'h0000_0000);
        cyc(1);
        chk("d1_save_on", 32'(save), 32'h0000_0002);
        cyc(3);
        chk("d1_save_last", 32'(save), 32'h0000_0002);
        cyc(1);
        chk("d1_save_done", 32'(save), 32'h0000_0000);
        chk("d1_sw_off", 32'(sw), 32'h0000_000C);
        pwr_ack = 4'hC;
        cyc(1);
        domain_en = 4'hE;
        cyc(1);
        chk("d1_onreq_sw", 32'(sw), 32'h0000_000E);
        chk("d1_onreq_rst", 32'(rst_n), 32'h0000_000C);
        pwr_ack = 4'hE;
        cyc(1);
        chk("d1_restore", 32'(restore), 32'h0000_0002);
        chk("d1_model_ret", 32'(m_ret[1]), 32'h0000_0001);
        cyc(4);
        chk("d1_rstrel_rs", 32'(restore), 32'h0000_0000);
        chk("d1_rstrel_rn", 32'(rst_n), 32'h0000_000E);
        chk("d1_rstrel_iso", 32'(iso), 32'h0000_0003);
        cyc(4);
        chk("d1_isorel_iso", 32'(iso), 32'h0000_0001);
        chk("d1_isorel_rdy", 32'(ready), 32'h0000_000C);
        cyc(4);
        chk("d1_on_rdy", 32'(ready), 32'h0000_000E);
        chk("d1_on_busy", 32'(busy), 32'h0000_0000);

        // domain 2 down with the ack stuck high
        domain_en = 4'hA;
        cyc(5);
        chk("d2_sw_off", 32'(sw), 32'h0000_000A);
        cyc(15);
        chk("d2_err_pre", 32'(terr), 32'h0000_0000);
        cyc(1);
        chk("d2_err_set", 32'(terr), 32'h0000_0004);
        chk("d2_busy", 32'(busy), 32'h0000_0000);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        chk("d2_err_clr", 32'(terr), 32'h0000_0000);

        // domain 3 cancelled while isolating
        domain_en = 4'h2;
        cyc(1);
        chk("d3_iso", 32'(iso), 32'h0000_000D);
        cyc(1);
        domain_en = 4'hA;
        cyc(1);
        chk("d3_isorel_iso", 32'(iso), 32'h0000_0005);
        chk("d3_isorel_sw", 32'(sw), 32'h0000_000A);
        chk("d3_isorel_rdy", 32'(ready), 32'h0000_0002);
        cyc(3);
        chk("d3_rdy_pre", 32'(ready), 32'h0000_0002);
        cyc(1);
        chk("d3_rdy", 32'(ready), 32'h0000_000A);

        // domains 0 and 2 power up together
        domain_en = 4'hF;
        cyc(1);
        pwr_ack = 4'hF;
`ifdef POWER_SEQ_STAGGER_EN
        chk("pu_sw_first", 32'(sw), 32'h0000_000B);
        cyc(1);
        chk("pu_sw_wait", 32'(sw), 32'h0000_000B);
        cyc(1);
        chk("pu_sw_second", 32'(sw), 32'h0000_000F);
`else
        chk("pu_sw_both", 32'(sw), 32'h0000_000F);
        cyc(1);
        chk("pu_sw_hold", 32'(sw), 32'h0000_000F);
`endif
        cyc(20);
        chk("final_rdy", 32'(ready), 32'h0000_000F);
        chk("final_busy", 32'(busy), 32'h0000_0000);
        chk("final_err", 32'(terr), 32'h0000_0000);
        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
